// File: rtl/boot_loader_ctrl.sv
// Boot-time loader for the Hack program RAM.
// Receives a length-prefixed, XOR-checksummed image as a byte stream, writes
// the words into program RAM while holding the CPU in reset, then hands the
// RAM read port to the CPU fetch path once the image has been verified.
module boot_loader_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  input  logic [15:0]       pc,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_CHECK   = 3'd4,
    S_RUN     = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  // Largest legal word count is the full RAM depth, so the count needs one
  // bit more than the address.
  localparam logic [16:0]     DEPTH   = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] IDX_ZERO = {(ADDR_W+1){1'b0}};

  // Running image checksum: plain XOR over every data byte.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t              state_r;
  logic [7:0]          len_hi_r;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W:0]     idx_r;
  logic [7:0]          hi_r;
  logic [7:0]          xor_r;
  logic [ADDR_W-1:0]   ld_addr_r;
  logic [15:0]         ld_wdata_r;
  logic                ld_we_r;
  logic                rx_ready_r;
  logic                cpu_reset_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic                accept_s;
  logic [15:0]         len_word_s;
  logic                len_too_big_s;
  logic                len_zero_s;
  logic                last_word_s;
  logic                run_s;
  logic                pc_unused_s;

  // Handshake and length/index decode for the current byte.
  always_comb begin
    accept_s      = rx_valid && rx_ready_r;
    len_word_s    = {len_hi_r, rx_data};
    len_too_big_s = ({1'b0, len_word_s} > DEPTH);
    len_zero_s    = (len_word_s == 16'h0000);
    last_word_s   = ((idx_r + IDX_ONE) == len_r);
    run_s         = (state_r == S_RUN);
  end

  // High pc bits are deliberately dropped: fetch aliases modulo RAM depth.
  assign pc_unused_s = ^pc[15:ADDR_W];

  // Loader FSM: byte-stream parsing, RAM write strobe and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_LEN_HI;
      len_hi_r    <= 8'h00;
      len_r       <= IDX_ZERO;
      idx_r       <= IDX_ZERO;
      hi_r        <= 8'h00;
      xor_r       <= 8'h00;
      ld_addr_r   <= {ADDR_W{1'b0}};
      ld_wdata_r  <= 16'h0000;
      ld_we_r     <= 1'b0;
      rx_ready_r  <= 1'b1;
      cpu_reset_r <= 1'b1;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      ld_we_r <= 1'b0;
      case (state_r)
        S_LEN_HI: begin
          if (accept_s) begin
            len_hi_r <= rx_data;
            state_r  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            idx_r <= IDX_ZERO;
            xor_r <= 8'h00;
            len_r <= len_word_s[ADDR_W:0];
            if (len_too_big_s) begin
              state_r     <= S_ERROR;
              rx_ready_r  <= 1'b0;
              cpu_reset_r <= 1'b1;
              busy_r      <= 1'b0;
              done_r      <= 1'b0;
              err_r       <= 1'b1;
            end else if (len_zero_s) begin
              state_r <= S_CHECK;
            end else begin
              state_r <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (accept_s) begin
            hi_r    <= rx_data;
            xor_r   <= csum_next(xor_r, rx_data);
            state_r <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept_s) begin
            ld_we_r    <= 1'b1;
            ld_addr_r  <= idx_r[ADDR_W-1:0];
            ld_wdata_r <= {hi_r, rx_data};
            xor_r      <= csum_next(xor_r, rx_data);
            idx_r      <= idx_r + IDX_ONE;
            if (last_word_s) begin
              state_r <= S_CHECK;
            end else begin
              state_r <= S_DATA_HI;
            end
          end
        end
        S_CHECK: begin
          if (accept_s) begin
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            if (rx_data == xor_r) begin
              state_r     <= S_RUN;
              cpu_reset_r <= 1'b0;
              done_r      <= 1'b1;
              err_r       <= 1'b0;
            end else begin
              state_r     <= S_ERROR;
              cpu_reset_r <= 1'b1;
              done_r      <= 1'b0;
              err_r       <= 1'b1;
            end
          end
        end
        S_RUN, S_ERROR: begin
          if (start) begin
            state_r     <= S_LEN_HI;
            rx_ready_r  <= 1'b1;
            cpu_reset_r <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_LEN_HI;
          rx_ready_r  <= 1'b1;
          cpu_reset_r <= 1'b1;
          busy_r      <= 1'b1;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
        end
      endcase
    end
  end

  // Program-RAM port mux: CPU fetch owns the port in RUN, loader otherwise.
  always_comb begin
    mem_wdata = ld_wdata_r;
    if (run_s) begin
      mem_addr    = pc[ADDR_W-1:0];
      mem_we      = 1'b0;
      instruction = mem_rdata;
    end else begin
      mem_addr    = ld_addr_r;
      mem_we      = ld_we_r;
      instruction = 16'h0000;
    end
  end

  assign rx_ready  = rx_ready_r;
  assign cpu_reset = cpu_reset_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl with a synchronous RAM model.
module tb_boot_loader_ctrl;

  localparam int ADDR_W = 11;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic [15:0]       pc;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic [15:0]       mem_rdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wq_addr [$];
  logic [15:0]       wq_data [$];
  logic [15:0]       exp_w [0:3];

  boot_loader_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .start(start), .pc(pc), .instruction(instruction),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, write on mem_we.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Log every write strobe cycle seen by the RAM.
  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte after an optional idle gap; return once it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    logic ok;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      rdy = rx_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    rx_valid = 1'b0;
    if (!ok) check_eq("rx_accept_timeout", 32'(ok), 32'd1);
  endtask

  // Send an image of n words taken from exp_w, with random gaps up to gmax.
  task automatic send_image(input int n, input logic [7:0] csum, input int gmax);
    send_byte(8'(n >> 8), $urandom_range(0, gmax));
    send_byte(8'(n), $urandom_range(0, gmax));
    for (int i = 0; i < n; i++) begin
      send_byte(exp_w[i][15:8], $urandom_range(0, gmax));
      send_byte(exp_w[i][7:0], $urandom_range(0, gmax));
    end
    send_byte(csum, $urandom_range(0, gmax));
  endtask

  task automatic check_writes(input string tag, input int n);
    check_eq({tag, "_count"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      check_eq({tag, "_addr"}, 32'(wq_addr[i]), 32'(i));
      check_eq({tag, "_data"}, 32'(wq_data[i]), 32'(exp_w[i]));
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; start = 1'b0; pc = 16'h0000;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'h0000;
    repeat (3) tick();

    // Reset values
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_instr", 32'(instruction), 32'd0);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Basic 3-word load, checksum 0x00
    exp_w[0] = 16'hEA10; exp_w[1] = 16'h0001; exp_w[2] = 16'hFC07;
    clear_log();
    send_image(3, 8'h00, 0);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_cpu_reset", 32'(cpu_reset), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_rx_ready", 32'(rx_ready), 32'd0);
    check_writes("t1_wr", 3);
    pc = 16'h0001;
    tick();
    check_eq("t1_fetch_pc1", 32'(instruction), 32'h0001);
    check_eq("t1_run_we", 32'(mem_we), 32'd0);
    pc = 16'h0802;
    tick();
    check_eq("t1_fetch_alias", 32'(instruction), 32'hFC07);
    pc = 16'h0000;

    // Empty image
    pulse_start();
    check_eq("t2_restart_done", 32'(done), 32'd0);
    check_eq("t2_restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("t2_restart_instr", 32'(instruction), 32'd0);
    clear_log();
    send_image(0, 8'h00, 0);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_cpu_reset", 32'(cpu_reset), 32'd0);
    check_writes("t2_wr", 0);

    // Bad checksum, then recovery
    pulse_start();
    exp_w[0] = 16'h1234;
    clear_log();
    send_image(1, 8'h00, 0);
    check_eq("t3_err", 32'(err), 32'd1);
    check_eq("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("t3_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("t3_done", 32'(done), 32'd0);
    check_eq("t3_instr", 32'(instruction), 32'd0);
    pulse_start();
    check_eq("t3_restart_err", 32'(err), 32'd0);
    clear_log();
    send_image(1, 8'h26, 0);
    check_eq("t3_recover_done", 32'(done), 32'd1);
    check_eq("t3_recover_err", 32'(err), 32'd0);
    check_writes("t3_wr", 1);

    // Oversize length
    pulse_start();
    clear_log();
    send_byte(8'h08, 0);
    send_byte(8'h01, 0);
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check_writes("t4_wr", 0);

    // Full-depth length is legal
    pulse_start();
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    check_eq("t4b_err", 32'(err), 32'd0);
    check_eq("t4b_busy", 32'(busy), 32'd1);
    check_eq("t4b_rx_ready", 32'(rx_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    // 4-word load gap-free, then with random gaps
    exp_w[0] = 16'hA5C3; exp_w[1] = 16'h0F0F; exp_w[2] = 16'h1357; exp_w[3] = 16'hBEEF;
    clear_log();
    send_image(4, 8'h73, 0);
    check_eq("t5_done", 32'(done), 32'd1);
    check_writes("t5_wr", 4);
    pulse_start();
    clear_log();
    send_image(4, 8'h73, 5);
    check_eq("t5g_done", 32'(done), 32'd1);
    check_writes("t5g_wr", 4);

    // Reset mid-load right after a write strobe
    pulse_start();
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 2; i++) begin
      send_byte(exp_w[i][15:8], 0);
      send_byte(exp_w[i][7:0], 0);
    end
    check_eq("t6_pre_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_we", 32'(mem_we), 32'd0);
    check_eq("t6_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("t6_rst_busy", 32'(busy), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(exp_w[0][15:8], 0);
    pulse_start();
    check_eq("t6_start_ignored_busy", 32'(busy), 32'd1);
    check_eq("t6_start_ignored_err", 32'(err), 32'd0);
    send_byte(exp_w[0][7:0], 0);
    for (int i = 1; i < 4; i++) begin
      send_byte(exp_w[i][15:8], 0);
      send_byte(exp_w[i][7:0], 0);
    end
    send_byte(8'h73, 0);
    check_eq("t6_done", 32'(done), 32'd1);
    check_eq("t6_cpu_reset", 32'(cpu_reset), 32'd0);
    check_writes("t6_wr", 4);
    pc = 16'h0003;
    tick();
    check_eq("t6_fetch", 32'(instruction), 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
